// File: rtl/match_lock_monitor_if.sv
// Bundle carrying the equality-bit stream into the lock monitor and its status back out.
// Qualifier semantics: eq_in and err_clr are sampled at each rising edge; eq_in only when en=1.
interface match_lock_monitor_if #(
  parameter int CNT_W = 16
);
  logic             eq_in;
  logic             en;
  logic             err_clr;
  logic             locked;
  logic             lock_pulse;
  logic             lost_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       state;

  modport master (
    output eq_in, en, err_clr,
    input  locked, lock_pulse, lost_pulse, err_cnt, state
  );

  modport slave (
    input  eq_in, en, err_clr,
    output locked, lock_pulse, lost_pulse, err_cnt, state
  );
endinterface

// File: rtl/match_lock_monitor.sv
// Qualifies a per-cycle equality bit into a lock status with acquire/loss hysteresis
// and counts mismatches seen while locked (saturating).
module match_lock_monitor #(
  parameter int LOCK_LEN = 8,
  parameter int LOSS_LEN = 4,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  match_lock_monitor_if.slave   bus
);

  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    LOCKED = 2'b01,
    HOLD   = 2'b10,
    BAD    = 2'b11
  } st_t;

  localparam logic [7:0] RUN_LAST  = 8'(LOCK_LEN - 1);
  localparam logic [7:0] MISS_LAST = 8'(LOSS_LEN - 1);

  st_t              state_q;
  logic [7:0]       run_q;
  logic [7:0]       miss_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             locked_q;
  logic             lock_pulse_q;
  logic             lost_pulse_q;
  logic             err_inc;

  assign err_inc = bus.en && !bus.eq_in && (state_q == LOCKED || state_q == HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SEARCH;
      run_q        <= '0;
      miss_q       <= '0;
      err_cnt_q    <= '0;
      locked_q     <= 1'b0;
      lock_pulse_q <= 1'b0;
      lost_pulse_q <= 1'b0;
    end else begin
      lock_pulse_q <= 1'b0;
      lost_pulse_q <= 1'b0;

      // Clear has priority over a same-edge increment; count sticks at all-ones.
      if (bus.err_clr)
        err_cnt_q <= '0;
      else if (err_inc && err_cnt_q != {CNT_W{1'b1}})
        err_cnt_q <= err_cnt_q + 1'b1;

      if (state_q == BAD) begin
        // Illegal encoding recovers regardless of en.
        state_q  <= SEARCH;
        run_q    <= '0;
        miss_q   <= '0;
        locked_q <= 1'b0;
      end else if (bus.en) begin
        case (state_q)
          SEARCH: begin
            if (bus.eq_in) begin
              if (run_q == RUN_LAST) begin
                state_q      <= LOCKED;
                run_q        <= '0;
                locked_q     <= 1'b1;
                lock_pulse_q <= 1'b1;
              end else begin
                run_q <= run_q + 8'd1;
              end
            end else begin
              run_q <= '0;
            end
          end
          LOCKED: begin
            if (!bus.eq_in) begin
              state_q <= HOLD;
              miss_q  <= 8'd1;
            end
          end
          HOLD: begin
            if (bus.eq_in) begin
              state_q <= LOCKED;
              miss_q  <= '0;
            end else if (miss_q == MISS_LAST) begin
              state_q      <= SEARCH;
              miss_q       <= '0;
              run_q        <= '0;
              locked_q     <= 1'b0;
              lost_pulse_q <= 1'b1;
            end else begin
              miss_q <= miss_q + 8'd1;
            end
          end
          default: begin
            state_q  <= SEARCH;
            run_q    <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.state      = state_q;
  assign bus.locked     = locked_q;
  assign bus.lock_pulse = lock_pulse_q;
  assign bus.lost_pulse = lost_pulse_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_match_lock_monitor.sv
// Directed bench for match_lock_monitor with LOCK_LEN=8, LOSS_LEN=4, CNT_W=4.
module tb_match_lock_monitor;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  match_lock_monitor_if #(.CNT_W(4)) bus ();

  match_lock_monitor #(
    .LOCK_LEN (8),
    .LOSS_LEN (4),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, return 1 time unit after it.
  task automatic cyc(input logic eq, input logic en, input logic clr);
    bus.eq_in   = eq;
    bus.en      = en;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic [1:0] st, input logic lk,
                            input logic lp, input logic sp, input logic [3:0] ec);
    chk({tag, "_state"},  32'(bus.state),      32'(st));
    chk({tag, "_locked"}, 32'(bus.locked),     32'(lk));
    chk({tag, "_lockp"},  32'(bus.lock_pulse), 32'(lp));
    chk({tag, "_lostp"},  32'(bus.lost_pulse), 32'(sp));
    chk({tag, "_err"},    32'(bus.err_cnt),    32'(ec));
  endtask

  initial begin
    int model_err;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.eq_in   = 1'b0;
    bus.en      = 1'b0;
    bus.err_clr = 1'b0;

    cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk_status("reset", 2'b00, 0, 0, 0, 4'd0);
    reset = 1'b1;

    // 1: eight matches acquire lock
    for (int i = 1; i <= 7; i++) begin
      cyc(1, 1, 0);
      chk("acq_locked", 32'(bus.locked), 32'd0);
      chk("acq_lockp",  32'(bus.lock_pulse), 32'd0);
    end
    cyc(1, 1, 0);
    chk_status("acq8", 2'b01, 1, 1, 0, 4'd0);
    cyc(1, 1, 0);
    chk_status("acq9", 2'b01, 1, 0, 0, 4'd0);

    // 3: short mismatch runs never lose lock
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 1, 0);
      chk_status("hold_a", 2'b10, 1, 0, 0, 4'(i));
    end
    cyc(1, 1, 0);
    chk_status("relock", 2'b01, 1, 0, 0, 4'd3);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 1, 0);
      chk_status("hold_b", 2'b10, 1, 0, 0, 4'(3 + i));
    end
    cyc(1, 1, 0);
    chk_status("relock2", 2'b01, 1, 0, 0, 4'd6);
    cyc(1, 1, 1);
    chk_status("clr", 2'b01, 1, 0, 0, 4'd0);

    // 4: four mismatches lose lock
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 1, 0);
      chk_status("loss_run", 2'b10, 1, 0, 0, 4'(i));
    end
    cyc(0, 1, 0);
    chk_status("lost", 2'b00, 0, 0, 1, 4'd4);
    cyc(0, 1, 0);
    chk_status("lost_next", 2'b00, 0, 0, 0, 4'd4);

    // 2: a mismatch in SEARCH restarts the run without counting
    for (int i = 1; i <= 7; i++) cyc(1, 1, 0);
    chk_status("pre_break", 2'b00, 0, 0, 0, 4'd4);
    cyc(0, 1, 0);
    chk_status("break", 2'b00, 0, 0, 0, 4'd4);
    for (int i = 1; i <= 7; i++) begin
      cyc(1, 1, 0);
      chk("rerun_locked", 32'(bus.locked), 32'd0);
    end
    cyc(1, 1, 0);
    chk_status("reacq", 2'b01, 1, 1, 0, 4'd4);

    // 5: saturation of the mismatch counter
    cyc(1, 1, 1);
    chk("sat_clr", 32'(bus.err_cnt), 32'd0);
    model_err = 0;
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < ((r < 6) ? 3 : 2); k++) begin
        cyc(0, 1, 0);
        model_err = (model_err < 15) ? model_err + 1 : 15;
        chk("sat_cnt", 32'(bus.err_cnt), 32'(model_err));
        chk("sat_state", 32'(bus.state), 32'd2);
      end
      cyc(1, 1, 0);
      chk("sat_relock", 32'(bus.state), 32'd1);
    end
    chk("sat_final", 32'(bus.err_cnt), 32'd15);
    cyc(0, 1, 1);
    chk_status("clr_vs_inc", 2'b10, 1, 0, 0, 4'd0);
    cyc(0, 1, 0);
    chk_status("miss2", 2'b10, 1, 0, 0, 4'd1);

    // 6: en=0 freezes everything mid-HOLD
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0);
      chk_status("frozen", 2'b10, 1, 0, 0, 4'd1);
    end
    cyc(0, 1, 0);
    chk_status("miss3", 2'b10, 1, 0, 0, 4'd2);

    #2;
    reset = 1'b0;
    #1;
    chk_status("async_rst", 2'b00, 0, 0, 0, 4'd0);
    cyc(0, 1, 0);
    chk_status("rst_held", 2'b00, 0, 0, 0, 4'd0);
    reset = 1'b1;
    cyc(0, 1, 0);
    chk_status("post_rst", 2'b00, 0, 0, 0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
